// File: rtl/cuckoo_hash_if.sv
// Handshake bundle for the cuckoo-hash insertion engine.
// The master drives keys and start; the slave (engine) returns status.
interface cuckoo_hash_if #(
  parameter int KEY_W = 32
);
  logic [KEY_W-1:0] num;
  logic             start;
  logic             ready;
  logic             done;
  logic             fail;
  logic [KEY_W-1:0] fail_key;
  logic [4:0]       kicks;

  modport master (
    output num, start,
    input  ready, done, fail, fail_key, kicks
  );

  modport slave (
    input  num, start,
    output ready, done, fail, fail_key, kicks
  );
endinterface

// File: rtl/cuckoo_hash_top.sv
// Two-table cuckoo-hash insertion engine: storage block m1 plus a
// kick-limited insertion FSM that ping-pongs the carried key between tables.
module cuckoo_hash_mem #(
  parameter int TABLE_SIZE = 20,
  parameter int KEY_W      = 32,
  parameter int IDX_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd1_idx,
  output logic [KEY_W-1:0] rd1_key,
  output logic             rd1_filled,
  input  logic [IDX_W-1:0] rd2_idx,
  output logic [KEY_W-1:0] rd2_key,
  output logic             rd2_filled,
  input  logic             wr1_en,
  input  logic [IDX_W-1:0] wr1_idx,
  input  logic [KEY_W-1:0] wr1_key,
  input  logic             wr2_en,
  input  logic [IDX_W-1:0] wr2_idx,
  input  logic [KEY_W-1:0] wr2_key
);
  logic [KEY_W-1:0]      table1 [TABLE_SIZE];
  logic [KEY_W-1:0]      table2 [TABLE_SIZE];
  logic [TABLE_SIZE-1:0] table1_filled;
  logic [TABLE_SIZE-1:0] table2_filled;

  assign rd1_key    = table1[rd1_idx];
  assign rd1_filled = table1_filled[rd1_idx];
  assign rd2_key    = table2[rd2_idx];
  assign rd2_filled = table2_filled[rd2_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        table1[i] <= '0;
        table2[i] <= '0;
      end
      table1_filled <= '0;
      table2_filled <= '0;
    end else begin
      if (wr1_en) begin
        table1[wr1_idx]        <= wr1_key;
        table1_filled[wr1_idx] <= 1'b1;
      end
      if (wr2_en) begin
        table2[wr2_idx]        <= wr2_key;
        table2_filled[wr2_idx] <= 1'b1;
      end
    end
  end
endmodule

module cuckoo_hash_top #(
  parameter int TABLE_SIZE = 20,
  parameter int KEY_W      = 32,
  parameter int MAX_KICKS  = 16
) (
  input  logic         clk,
  input  logic         reset,
  cuckoo_hash_if.slave bus
);
  localparam int IDX_W = $clog2(TABLE_SIZE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_PUT1  = 3'd2;
  localparam logic [2:0] S_PUT2  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  function automatic logic [IDX_W-1:0] h1(input logic [KEY_W-1:0] k);
    return IDX_W'(k % KEY_W'(TABLE_SIZE));
  endfunction

  function automatic logic [IDX_W-1:0] h2(input logic [KEY_W-1:0] k);
    return IDX_W'((k / KEY_W'(TABLE_SIZE)) % KEY_W'(TABLE_SIZE));
  endfunction

  logic [2:0]       state_q, state_d;
  logic [KEY_W-1:0] carry_q, carry_d;
  logic [4:0]       kicks_q, kicks_d;
  logic [KEY_W-1:0] fail_key_q, fail_key_d;

  logic [IDX_W-1:0] idx1, idx2;
  logic [KEY_W-1:0] rd1_key, rd2_key;
  logic             rd1_filled, rd2_filled;
  logic             wr1_en, wr2_en;

  // Both hash slots always track the carried key, so CHECK and PUTx share one read path.
  assign idx1 = h1(carry_q);
  assign idx2 = h2(carry_q);

  cuckoo_hash_mem #(
    .TABLE_SIZE (TABLE_SIZE),
    .KEY_W      (KEY_W),
    .IDX_W      (IDX_W)
  ) m1 (
    .clk        (clk),
    .reset      (reset),
    .rd1_idx    (idx1),
    .rd1_key    (rd1_key),
    .rd1_filled (rd1_filled),
    .rd2_idx    (idx2),
    .rd2_key    (rd2_key),
    .rd2_filled (rd2_filled),
    .wr1_en     (wr1_en),
    .wr1_idx    (idx1),
    .wr1_key    (carry_q),
    .wr2_en     (wr2_en),
    .wr2_idx    (idx2),
    .wr2_key    (carry_q)
  );

  always_comb begin
    state_d    = state_q;
    carry_d    = carry_q;
    kicks_d    = kicks_q;
    fail_key_d = fail_key_q;
    wr1_en     = 1'b0;
    wr2_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          carry_d    = bus.num;
          kicks_d    = '0;
          fail_key_d = '0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((rd1_filled && rd1_key == carry_q) || (rd2_filled && rd2_key == carry_q))
          state_d = S_DONE;
        else
          state_d = S_PUT1;
      end
      S_PUT1: begin
        if (!rd1_filled) begin
          wr1_en  = 1'b1;
          state_d = S_DONE;
        end else if (kicks_q == 5'(MAX_KICKS)) begin
          fail_key_d = carry_q;
          state_d    = S_FAIL;
        end else begin
          wr1_en  = 1'b1;
          carry_d = rd1_key;
          kicks_d = kicks_q + 5'd1;
          state_d = S_PUT2;
        end
      end
      S_PUT2: begin
        if (!rd2_filled) begin
          wr2_en  = 1'b1;
          state_d = S_DONE;
        end else if (kicks_q == 5'(MAX_KICKS)) begin
          fail_key_d = carry_q;
          state_d    = S_FAIL;
        end else begin
          wr2_en  = 1'b1;
          carry_d = rd2_key;
          kicks_d = kicks_q + 5'd1;
          state_d = S_PUT1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      carry_q    <= '0;
      kicks_q    <= '0;
      fail_key_q <= '0;
    end else begin
      state_q    <= state_d;
      carry_q    <= carry_d;
      kicks_q    <= kicks_d;
      fail_key_q <= fail_key_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.fail     = (state_q == S_FAIL);
  assign bus.fail_key = fail_key_q;
  assign bus.kicks    = kicks_q;
endmodule

// File: tb/tb_cuckoo_hash_top.sv
// Directed bench for cuckoo_hash_top, checked against an algorithmic
// cuckoo-insertion model and a few hand-computed table contents.
module tb_cuckoo_hash_top;
  localparam int TS = 20;
  localparam int MK = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cuckoo_hash_if #(.KEY_W(32)) bus ();

  cuckoo_hash_top #(.TABLE_SIZE(TS), .KEY_W(32), .MAX_KICKS(MK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] m_t1 [TS];
  logic [31:0] m_t2 [TS];
  bit          m_f1 [TS];
  bit          m_f2 [TS];
  int          m_kicks, m_lat;
  bit          m_ok, m_fail;
  logic [31:0] m_fkey;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < TS; i++) begin
      m_t1[i] = '0; m_t2[i] = '0; m_f1[i] = 0; m_f2[i] = 0;
    end
  endfunction

  // Plain cuckoo insertion: alternate tables, swapping with occupants.
  function automatic void model_insert(input logic [31:0] key);
    int a, b, s;
    logic [31:0] c, tmp;
    bit side1, fin;
    a = int'(key % TS);
    b = int'((key / TS) % TS);
    m_ok = 0; m_fail = 0; m_kicks = 0; m_fkey = '0;
    if ((m_f1[a] && m_t1[a] == key) || (m_f2[b] && m_t2[b] == key)) begin
      m_ok = 1; m_lat = 2;
      return;
    end
    c = key; side1 = 1; fin = 0;
    for (int it = 0; it <= MK + 1 && !fin; it++) begin
      s = side1 ? int'(c % TS) : int'((c / TS) % TS);
      if (side1 ? !m_f1[s] : !m_f2[s]) begin
        if (side1) begin m_t1[s] = c; m_f1[s] = 1; end
        else       begin m_t2[s] = c; m_f2[s] = 1; end
        m_ok = 1; m_lat = 3 + m_kicks; fin = 1;
      end else if (m_kicks == MK) begin
        m_fail = 1; m_fkey = c; m_lat = 3 + MK; fin = 1;
      end else begin
        if (side1) begin tmp = m_t1[s]; m_t1[s] = c; end
        else       begin tmp = m_t2[s]; m_t2[s] = c; end
        c = tmp; m_kicks++; side1 = !side1;
      end
    end
  endfunction

  task automatic check_tables(input string tag);
    for (int i = 0; i < TS; i++) begin
      chk($sformatf("%s t1_filled[%0d]", tag, i), 32'(dut.m1.table1_filled[i]), 32'(m_f1[i]));
      chk($sformatf("%s t2_filled[%0d]", tag, i), 32'(dut.m1.table2_filled[i]), 32'(m_f2[i]));
      if (m_f1[i]) chk($sformatf("%s table1[%0d]", tag, i), dut.m1.table1[i], m_t1[i]);
      if (m_f2[i]) chk($sformatf("%s table2[%0d]", tag, i), dut.m1.table2[i], m_t2[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b0; bus.num = '0;
    @(negedge clk);
    model_reset();
    chk("rst ready", 32'(bus.ready), 1);
    chk("rst done", 32'(bus.done), 0);
    chk("rst fail", 32'(bus.fail), 0);
    chk("rst kicks", 32'(bus.kicks), 0);
    chk("rst fail_key", bus.fail_key, 0);
    check_tables("rst");
    reset = 1'b0;
  endtask

  // Cycle-accurate compare of one insertion against the model's outcome.
  task automatic insert(input logic [31:0] key, input string tag);
    model_insert(key);
    @(negedge clk);
    chk({tag, " ready before start"}, 32'(bus.ready), 1);
    bus.num = key; bus.start = 1'b1;
    for (int c = 1; c <= m_lat; c++) begin
      @(negedge clk);
      chk($sformatf("%s ready c%0d", tag, c), 32'(bus.ready), 0);
      chk($sformatf("%s done c%0d", tag, c), 32'(bus.done), 32'(c == m_lat && m_ok));
      chk($sformatf("%s fail c%0d", tag, c), 32'(bus.fail), 32'(c == m_lat && m_fail));
      if (c == m_lat) begin
        chk({tag, " kicks"}, 32'(bus.kicks), 32'(m_kicks));
        if (m_fail) chk({tag, " fail_key"}, bus.fail_key, m_fkey);
      end
      bus.start = (c == 1);
      bus.num   = (c == 1) ? ~key : key;
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, " ready after"}, 32'(bus.ready), 1);
    chk({tag, " done after"}, 32'(bus.done), 0);
    chk({tag, " fail after"}, 32'(bus.fail), 0);
    chk({tag, " kicks held"}, 32'(bus.kicks), 32'(m_kicks));
    check_tables(tag);
  endtask

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.num = '0;
    do_reset();

    insert(32'd38, "ins38");
    chk("pin38 lat", 32'(m_lat), 3);
    chk("pin38 t1f[18]", 32'(dut.m1.table1_filled[18]), 1);
    chk("pin38 t1[18]", dut.m1.table1[18], 38);
    chk("pin38 kicks", 32'(bus.kicks), 0);

    insert(32'd58, "ins58");
    chk("pin58 t1[18]", dut.m1.table1[18], 58);
    chk("pin58 t2[1]", dut.m1.table2[1], 38);
    chk("pin58 t2f[1]", 32'(dut.m1.table2_filled[1]), 1);
    chk("pin58 kicks", 32'(bus.kicks), 1);

    insert(32'd18, "ins18");
    chk("pin18 t1[18]", dut.m1.table1[18], 18);
    chk("pin18 t2[2]", dut.m1.table2[2], 58);
    chk("pin18 t2[1]", dut.m1.table2[1], 38);
    chk("pin18 kicks", 32'(bus.kicks), 1);

    insert(32'd58, "dup58");
    chk("pindup lat", 32'(m_lat), 2);
    chk("pindup kicks", 32'(bus.kicks), 0);

    insert(32'd5, "ins5");
    insert(32'd25, "ins25");
    insert(32'hFFFF_FFFF, "insmax");
    chk("pinmax t1[15]", dut.m1.table1[15], 32'hFFFF_FFFF);

    do_reset();
    insert(32'd0, "ins0");
    chk("pin0 t1f[0]", 32'(dut.m1.table1_filled[0]), 1);
    insert(32'd400, "ins400");
    insert(32'd800, "ins800");
    chk("pinfail lat", 32'(m_lat), 19);
    chk("pinfail model key", m_fkey, 400);
    chk("pinfail kicks", 32'(bus.kicks), 16);
    chk("pinfail fail_key", bus.fail_key, 400);
    chk("pinfail t1[0]", dut.m1.table1[0], 0);
    chk("pinfail t2[0]", dut.m1.table2[0], 800);

    // Reset landing in the middle of a long kick chain.
    do_reset();
    insert(32'd0, "mid0");
    insert(32'd400, "mid400");
    @(negedge clk);
    bus.num = 32'd800; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid busy", 32'(bus.ready), 0);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    chk("mid ready", 32'(bus.ready), 1);
    chk("mid done", 32'(bus.done), 0);
    chk("mid fail", 32'(bus.fail), 0);
    check_tables("mid");
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk($sformatf("post-rst quiet c%0d", c), 32'(bus.done | bus.fail), 0);
      chk($sformatf("post-rst ready c%0d", c), 32'(bus.ready), 1);
    end
    insert(32'd800, "after_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cuckoo_hash_top.md
Name: cuckoo_hash_top

Overview:
- Two-table cuckoo-hash insertion engine for 32-bit keys, 20 slots per table.
- A key presented on `num` with a `start` pulse is inserted by displacing ("kicking") occupants between the tables until an empty slot is found or the kick budget runs out.
- Storage lives in a sub-instance named `m1`, which holds the arrays `table1`, `table1_filled`, `table2` and `table2_filled`. Verification reads these hierarchically as `m1.table1[i]` etc.
- The block is a standalone hashing/lookup-table front end.

Parameters:
- TABLE_SIZE, 20, slots per table; also the hash modulus.
- KEY_W, 32, key width.
- MAX_KICKS, 16, maximum evictions per insertion before declaring failure.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- num  input  KEY_W  key to insert; sampled on the start cycle
- start  input  1  one-cycle insert request; honoured only when ready=1
- ready  output  1  engine idle and able to accept start
- done  output  1  one-cycle pulse: insertion succeeded or key was already present
- fail  output  1  one-cycle pulse: kick budget exhausted
- fail_key  output  KEY_W  key left without a slot; valid when fail=1, held until the next start
- kicks  output  5  evictions used by the last insertion; held until the next start

Behaviour:
- Hash functions:
  - h1(k) = k mod 20
  - h2(k) = (k / 20) mod 20
  - Both use unsigned arithmetic on the full 32 bits. Constant divide/modulo is acceptable.
- Reset (synchronous, active-high, highest priority, including mid-insertion):
  - all table1/table2 entries and filled bits cleared to 0
  - ready=1; done=0, fail=0, fail_key=0, kicks=0
  - any in-flight insertion is abandoned
- FSM states: IDLE, CHECK, PUT1, PUT2, DONE, FAIL.
- IDLE:
  - ready=1.
  - On start: latch num into the carry register, clear the kick counter, go to CHECK.
- CHECK (1 cycle, duplicate check):
  - If table1_filled[h1]&&table1[h1]==key, or table2_filled[h2]&&table2[h2]==key, go to DONE with no table change.
  - Otherwise go to PUT1.
- PUT1 (write carry into table1[h1(carry)]):
  - Slot empty: write, set filled, go to DONE.
  - Slot full and kicks==MAX_KICKS: go to FAIL with fail_key=carry; no write.
  - Slot full otherwise: write carry, move old occupant into carry, kicks+1, go to PUT2.
- PUT2: same as PUT1 but uses table2 and h2; on eviction go back to PUT1.
- DONE/FAIL:
  - Pulse done or fail for one cycle, then return to IDLE.
  - Tables keep their contents after FAIL (the evicted key is lost from the tables and reported on fail_key).
- Latency: each table placement takes one cycle.
  - Start in cycle 0 → CHECK in cycle 1 → first PUT1 in cycle 2.
  - Direct insert: done high in cycle 3.
  - Each eviction adds 1 cycle.
- start while ready=0 is ignored. Changes on num outside the start cycle are ignored.
- Tables are never cleared except by reset. Inserting a key equal to 0 is legal; occupancy is tracked only by the filled bits.

Test Plan:
- Reset, then insert 38 → done in cycle 3. Then:
  - table1_filled[18]=1, table1[18]=38
  - every other filled bit 0
  - kicks=0
- After 38, insert 58 (h1=18) → done after one eviction:
  - table1[18]=58
  - table2[1]=38, table2_filled[1]=1
  - kicks=1
- Continue by inserting 18 (h1=18) → table1[18]=18; 58 evicted to table2[2] (h2(58)=2); table2[1]=38 unchanged; kicks=1.
- Insert 58 again with 58 already present → done in cycle 2 with no table change; kicks=0.
- Reset, then insert 0, 400, 800 (all have h1=0, h2=0) → third insert pulses fail:
  - kicks=MAX_KICKS=16
  - fail_key is one of {0,400,800}
  - table1[0] and table2[0] filled with the other two keys
- Assert reset during a multi-kick insertion → next cycle all filled bits are 0, ready=1, and no done/fail pulse occurs.
